// File: rtl/mem_pkg.sv
// Shared constants and encodings for the line-memory arbiter and its round-robin picker.
package mem_pkg;

    localparam int ADDR_W   = 32;
    localparam int LINE_W   = 512;
    localparam int OFFSET_W = 6;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        RESP  = 2'd3
    } state_e;

    typedef enum logic {
        IC = 1'b0,
        DC = 1'b1
    } owner_e;

    // Memory only deals in whole lines, so the byte offset is always dropped.
    function automatic logic [ADDR_W-1:0] line_align(input logic [ADDR_W-1:0] a);
        return {a[ADDR_W-1:OFFSET_W], {OFFSET_W{1'b0}}};
    endfunction

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin picker: on a tie the requester that was not granted last wins.
module rr_arb2
    import mem_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic [1:0] req,
    input  logic       update,
    output logic [1:0] grant
);

    owner_e last_grant_q, last_grant_d;

    // req[0] is the icache, req[1] the dcache.
    always_comb begin
        grant = 2'b00;
        case (req)
            2'b01:   grant = 2'b01;
            2'b10:   grant = 2'b10;
            2'b11:   grant = (last_grant_q == DC) ? 2'b01 : 2'b10;
            default: grant = 2'b00;
        endcase
    end

    always_comb begin
        last_grant_d = last_grant_q;
        if (update && (grant != 2'b00)) begin
            last_grant_d = grant[1] ? DC : IC;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            last_grant_q <= DC;
        end else begin
            last_grant_q <= last_grant_d;
        end
    end

endmodule

// File: rtl/line_mem_arbiter.sv
// Shares one line-wide memory port between the icache refill path and the dcache,
// one transaction at a time, with round-robin fairness between the two.
module line_mem_arbiter
    import mem_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              ic_addr_valid,
    input  logic [ADDR_W-1:0] ic_addr,
    output logic              ic_data_ready,
    output logic [LINE_W-1:0] ic_data,
    output logic [ADDR_W-1:0] ic_resp_addr,
    input  logic              dc_req_valid,
    input  logic              dc_we,
    input  logic [ADDR_W-1:0] dc_addr,
    input  logic [LINE_W-1:0] dc_wdata,
    output logic              dc_done,
    output logic [LINE_W-1:0] dc_rdata,
    output logic              mem_req_valid,
    input  logic              mem_req_ready,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [LINE_W-1:0] mem_wdata,
    input  logic              mem_resp_valid,
    input  logic [LINE_W-1:0] mem_rdata,
    output state_e            dbg_state
);

    state_e             state_q, state_d;
    owner_e             owner_q, owner_d;
    logic [ADDR_W-1:0]  addr_q, addr_d;
    logic               we_q, we_d;
    logic [LINE_W-1:0]  wdata_q, wdata_d;
    logic [LINE_W-1:0]  rdata_q, rdata_d;
    logic [1:0]         grant;
    logic               arb_update;

    assign arb_update = (state_q == IDLE);

    rr_arb2 u_arb (
        .clk    (clk),
        .rst_n  (rst_n),
        .req    ({dc_req_valid, ic_addr_valid}),
        .update (arb_update),
        .grant  (grant)
    );

    always_comb begin
        state_d = state_q;
        owner_d = owner_q;
        addr_d  = addr_q;
        we_d    = we_q;
        wdata_d = wdata_q;
        rdata_d = rdata_q;
        case (state_q)
            IDLE: begin
                if (grant[0]) begin
                    owner_d = IC;
                    addr_d  = line_align(ic_addr);
                    we_d    = 1'b0;
                    wdata_d = '0;
                    state_d = ISSUE;
                end else if (grant[1]) begin
                    owner_d = DC;
                    addr_d  = line_align(dc_addr);
                    we_d    = dc_we;
                    wdata_d = dc_wdata;
                    state_d = ISSUE;
                end
            end
            // Request transfers on a cycle with mem_req_valid and mem_req_ready both high;
            // address, we and wdata come from registers so they cannot move while stalled.
            ISSUE: begin
                if (mem_req_ready) state_d = WAIT;
            end
            WAIT: begin
                if (mem_resp_valid) begin
                    rdata_d = mem_rdata;
                    state_d = RESP;
                end
            end
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            owner_q <= IC;
            addr_q  <= '0;
            we_q    <= 1'b0;
            wdata_q <= '0;
            rdata_q <= '0;
        end else begin
            state_q <= state_d;
            owner_q <= owner_d;
            addr_q  <= addr_d;
            we_q    <= we_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
        end
    end

    assign mem_req_valid = (state_q == ISSUE);
    assign mem_we        = we_q;
    assign mem_addr      = addr_q;
    assign mem_wdata     = wdata_q;
    assign ic_data_ready = (state_q == RESP) && (owner_q == IC);
    assign dc_done       = (state_q == RESP) && (owner_q == DC);
    assign ic_data       = rdata_q;
    assign dc_rdata      = rdata_q;
    assign ic_resp_addr  = addr_q;
    assign dbg_state     = state_q;

endmodule

// File: tb/tb_line_mem_arbiter.sv
// Self-checking bench for line_mem_arbiter: transaction table plus hand-written arbitration/reset sequences.
module tb_line_mem_arbiter;
    import mem_pkg::*;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              ic_addr_valid = 1'b0;
    logic [31:0]       ic_addr = '0;
    logic              ic_data_ready;
    logic [511:0]      ic_data;
    logic [31:0]       ic_resp_addr;
    logic              dc_req_valid = 1'b0;
    logic              dc_we = 1'b0;
    logic [31:0]       dc_addr = '0;
    logic [511:0]      dc_wdata = '0;
    logic              dc_done;
    logic [511:0]      dc_rdata;
    logic              mem_req_valid;
    logic              mem_req_ready;
    logic              mem_we;
    logic [31:0]       mem_addr;
    logic [511:0]      mem_wdata;
    logic              mem_resp_valid;
    logic [511:0]      mem_rdata;
    state_e            dbg_state;

    line_mem_arbiter dut (
        .clk(clk), .rst_n(rst_n),
        .ic_addr_valid(ic_addr_valid), .ic_addr(ic_addr), .ic_data_ready(ic_data_ready),
        .ic_data(ic_data), .ic_resp_addr(ic_resp_addr),
        .dc_req_valid(dc_req_valid), .dc_we(dc_we), .dc_addr(dc_addr), .dc_wdata(dc_wdata),
        .dc_done(dc_done), .dc_rdata(dc_rdata),
        .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready), .mem_we(mem_we),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_resp_valid(mem_resp_valid),
        .mem_rdata(mem_rdata), .dbg_state(dbg_state)
    );

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;

    typedef struct {
        owner_e       owner;
        logic         we;
        logic [31:0]  addr;
        logic [511:0] wdata;
    } req_t;

    typedef struct {
        owner_e       owner;
        logic         we;
        logic [31:0]  addr;
        logic [31:0]  exp_addr;
        int           stall;
        int           delay;
        int           exp_lat;
    } vec_t;

    req_t exp_req_q[$];
    req_t exp_resp_q[$];
    int   n_cmp = 0;
    int   n_err = 0;
    int   stall_left = 0;
    int   resp_delay = 1;
    int   resp_cnt = 0;
    logic [31:0] resp_addr = '0;
    int   ic_pulses = 0;
    int   dc_pulses = 0;

    task automatic check(input string name, input logic [511:0] act, input logic [511:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [511:0] line_pat(input logic [31:0] a);
        return {8{a, ~a}};
    endfunction

    function automatic logic [511:0] rand_line();
        logic [511:0] l;
        for (int i = 0; i < 16; i++) l[i*32 +: 32] = $urandom;
        return l;
    endfunction

    task automatic apply_reset();
        rst_n = 1'b0;
        ic_addr_valid = 1'b0;
        dc_req_valid = 1'b0;
        stall_left = 0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    // ---------------- memory model + request scoreboard ----------------
    initial begin
        mem_req_ready = 1'b0;
        mem_resp_valid = 1'b0;
        mem_rdata = '0;
        forever begin
            @(negedge clk);
            mem_resp_valid = 1'b0;
            if (resp_cnt > 0) begin
                resp_cnt--;
                if (resp_cnt == 0) begin
                    mem_resp_valid = 1'b1;
                    mem_rdata = line_pat(resp_addr);
                end
            end
            mem_req_ready = 1'b0;
            if (mem_req_valid === 1'b1) begin
                check("req_expected", exp_req_q.size() > 0, 1'b1);
                if (exp_req_q.size() > 0) begin
                    check("mem_addr", mem_addr, exp_req_q[0].addr);
                    check("mem_we", mem_we, exp_req_q[0].we);
                    if (exp_req_q[0].we) check("mem_wdata", mem_wdata, exp_req_q[0].wdata);
                    if (stall_left > 0) begin
                        stall_left--;
                    end else begin
                        mem_req_ready = 1'b1;
                        resp_addr = mem_addr;
                        resp_cnt = resp_delay;
                        exp_resp_q.push_back(exp_req_q.pop_front());
                    end
                end
            end
        end
    end

    // ---------------- response scoreboard ----------------
    initial begin
        req_t r;
        forever begin
            @(negedge clk);
            if (ic_data_ready === 1'b1 || dc_done === 1'b1) begin
                if (ic_data_ready === 1'b1) ic_pulses++;
                if (dc_done === 1'b1) dc_pulses++;
                check("resp_expected", exp_resp_q.size() > 0, 1'b1);
                if (exp_resp_q.size() > 0) begin
                    r = exp_resp_q.pop_front();
                    check("ic_pulse_owner", ic_data_ready, r.owner == IC);
                    check("dc_pulse_owner", dc_done, r.owner == DC);
                    if (r.owner == IC) begin
                        check("ic_data", ic_data, line_pat(r.addr));
                        check("ic_resp_addr", ic_resp_addr, r.addr);
                    end else if (!r.we) begin
                        check("dc_rdata", dc_rdata, line_pat(r.addr));
                    end
                end
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic wait_pulse(input owner_e who, output int lat);
        bit got;
        got = 1'b0;
        lat = -1;
        for (int i = 1; i <= 80 && !got; i++) begin
            @(negedge clk);
            if ((who == IC && ic_data_ready === 1'b1) || (who == DC && dc_done === 1'b1)) begin
                got = 1'b1;
                lat = i;
            end
        end
        check(who == IC ? "ic_pulse_timeout" : "dc_pulse_timeout", got, 1'b1);
    endtask

    task automatic wait_state(input state_e s);
        bit got;
        got = 1'b0;
        for (int i = 0; i < 40 && !got; i++) begin
            @(negedge clk);
            if (dbg_state == s) got = 1'b1;
        end
        check("state_wait_timeout", got, 1'b1);
    endtask

    task automatic drive_req(input owner_e who, input logic [31:0] a, input logic we, input logic [511:0] wd);
        if (who == IC) begin
            ic_addr = a;
            ic_addr_valid = 1'b1;
        end else begin
            dc_addr = a;
            dc_we = we;
            dc_wdata = wd;
            dc_req_valid = 1'b1;
        end
    endtask

    task automatic drop_req(input owner_e who);
        if (who == IC) ic_addr_valid = 1'b0;
        else dc_req_valid = 1'b0;
    endtask

    task automatic hold_req(input owner_e who, input logic [31:0] a, input logic we, input logic [511:0] wd);
        int lat;
        drive_req(who, a, we, wd);
        wait_pulse(who, lat);
        drop_req(who);
    endtask

    task automatic run_one(input vec_t v);
        int lat;
        logic [511:0] wd;
        wd = rand_line();
        stall_left = v.stall;
        resp_delay = v.delay;
        exp_req_q.push_back('{v.owner, (v.owner == DC) ? v.we : 1'b0, v.exp_addr, wd});
        drive_req(v.owner, v.addr, v.we, wd);
        wait_pulse(v.owner, lat);
        drop_req(v.owner);
        check("latency", lat, v.exp_lat);
        repeat (2) @(negedge clk);
        if (v.owner == IC) check("ic_data_hold", ic_data, line_pat(v.exp_addr));
        else if (!v.we) check("dc_rdata_hold", dc_rdata, line_pat(v.exp_addr));
        check("idle_after", dbg_state, IDLE);
    endtask

    // ---------------- test sequence ----------------
    vec_t vecs[6];

    initial begin
        int ic0, dc0;
        vec_t v;

        vecs[0] = '{IC, 1'b0, 32'h0000_1234, 32'h0000_1200, 0, 2, 4};
        vecs[1] = '{DC, 1'b1, 32'h8000_0040, 32'h8000_0040, 3, 1, 6};
        vecs[2] = '{DC, 1'b0, 32'h0000_ABFF, 32'h0000_ABC0, 0, 1, 3};
        vecs[3] = '{IC, 1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFC0, 1, 3, 6};
        vecs[4] = '{DC, 1'b1, 32'h1234_567F, 32'h1234_5640, 2, 2, 6};
        vecs[5] = '{IC, 1'b0, 32'h0000_003F, 32'h0000_0000, 0, 1, 3};

        apply_reset();
        check("rst_state", dbg_state, IDLE);
        check("rst_mem_req_valid", mem_req_valid, 1'b0);
        check("rst_ic_data_ready", ic_data_ready, 1'b0);
        check("rst_dc_done", dc_done, 1'b0);
        check("rst_mem_we", mem_we, 1'b0);
        check("rst_mem_addr", mem_addr, 32'h0);
        check("rst_mem_wdata", mem_wdata, 512'h0);
        check("rst_ic_data", ic_data, 512'h0);

        for (int i = 0; i < 6; i++) run_one(vecs[i]);

        // Simultaneous from reset: IC wins the first tie, then DC.
        apply_reset();
        resp_delay = 1;
        exp_req_q.push_back('{IC, 1'b0, 32'h0000_0100, '0});
        exp_req_q.push_back('{DC, 1'b0, 32'h0000_0200, '0});
        fork
            hold_req(IC, 32'h0000_0100, 1'b0, '0);
            hold_req(DC, 32'h0000_0200, 1'b0, '0);
        join
        repeat (2) @(negedge clk);
        // One more IC-only grant, so the following tie must go to DC.
        exp_req_q.push_back('{IC, 1'b0, 32'h0000_0100, '0});
        hold_req(IC, 32'h0000_0100, 1'b0, '0);
        repeat (2) @(negedge clk);
        exp_req_q.push_back('{DC, 1'b0, 32'h0000_0200, '0});
        exp_req_q.push_back('{IC, 1'b0, 32'h0000_0100, '0});
        fork
            hold_req(IC, 32'h0000_0100, 1'b0, '0);
            hold_req(DC, 32'h0000_0200, 1'b0, '0);
        join
        repeat (2) @(negedge clk);

        // Starvation: IC keeps requesting for six lines, DC must get the second slot.
        apply_reset();
        exp_req_q.push_back('{IC, 1'b0, 32'h0001_0000, '0});
        exp_req_q.push_back('{DC, 1'b0, 32'h0000_0300, '0});
        for (int i = 1; i < 6; i++) exp_req_q.push_back('{IC, 1'b0, 32'h0001_0000 + 32'(i * 64), '0});
        fork
            begin
                int lat;
                ic_addr_valid = 1'b1;
                for (int i = 0; i < 6; i++) begin
                    ic_addr = 32'h0001_0000 + 32'(i * 64) + 32'h5;
                    wait_pulse(IC, lat);
                end
                ic_addr_valid = 1'b0;
            end
            hold_req(DC, 32'h0000_0300, 1'b0, '0);
        join
        repeat (2) @(negedge clk);

        // Withdrawn request: IC drops valid while in WAIT, pulse still fires once.
        begin
            int lat;
            ic0 = ic_pulses;
            resp_delay = 4;
            exp_req_q.push_back('{IC, 1'b0, 32'h0000_5000, '0});
            drive_req(IC, 32'h0000_5010, 1'b0, '0);
            wait_state(WAIT);
            drop_req(IC);
            wait_pulse(IC, lat);
            @(negedge clk);
            check("withdraw_idle", dbg_state, IDLE);
            repeat (5) @(negedge clk);
            check("withdraw_pulses", ic_pulses - ic0, 1);
        end

        // Reset in WAIT: transaction abandoned, late response ignored.
        ic0 = ic_pulses;
        dc0 = dc_pulses;
        resp_delay = 3;
        exp_req_q.push_back('{IC, 1'b0, 32'h0000_6040, '0});
        drive_req(IC, 32'h0000_6055, 1'b0, '0);
        wait_state(WAIT);
        rst_n = 1'b0;
        drop_req(IC);
        exp_resp_q.delete();
        @(negedge clk);
        rst_n = 1'b1;
        check("rst_wait_state", dbg_state, IDLE);
        check("rst_wait_req_valid", mem_req_valid, 1'b0);
        repeat (6) @(negedge clk);
        check("rst_wait_ic_pulses", ic_pulses - ic0, 0);
        check("rst_wait_dc_pulses", dc_pulses - dc0, 0);
        check("rst_wait_still_idle", dbg_state, IDLE);
        v = '{IC, 1'b0, 32'h0000_7001, 32'h0000_7000, 0, 1, 3};
        run_one(v);

        check("req_q_drained", exp_req_q.size(), 0);
        check("resp_q_drained", exp_resp_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

endmodule
